// File: rtl/oc8051_indi_pkg.sv
// Shared definitions for the 8051 indirect-access (@Ri) sequencer.
//   op_e      : operation codes as presented on the op port
//   state_e   : sequencer states
//   xchd_merge: nibble merge used by XCHD (high nibble of one byte,
//               low nibble of another)
package oc8051_indi_pkg;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_XCH  = 2'b10,
    OP_XCHD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WB    = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic logic [7:0] xchd_merge(input logic [7:0] hi_src,
                                            input logic [7:0] lo_src);
    return {hi_src[7:4], lo_src[3:0]};
  endfunction

endpackage

// File: rtl/oc8051_indi_acc.sv
// Indirect-access sequencer: performs MOV A,@Ri / MOV @Ri,x / XCH / XCHD
// against the synchronous internal RAM, forwarding same-address writes
// from other RAM masters into the captured read value.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, op, ri, acc_in request, operation, pointer, source data
//   busy, done          busy in ISSUE/CAPT/WB, one-cycle done in FIN
//   rd_data             result toward the accumulator
//   ram_rd_*            RAM read port (data valid the cycle after rd_en)
//   ram_wr_*            RAM write port
//   ext_wr*             snoop of writes by other RAM masters
//
// state | meaning
// IDLE  | waiting for req
// ISSUE | read strobe (rd/xch/xchd) or write strobe (write)
// CAPT  | RAM data (or snooped data) captured into mem
// WB    | write-back for xch/xchd, result to rd_data
// FIN   | done pulse; a new req may be accepted here
module oc8051_indi_acc
  import oc8051_indi_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] ri,
  input  logic [7:0] acc_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ram_rd_en,
  output logic [7:0] ram_rd_addr,
  input  logic [7:0] ram_rd_data,
  output logic       ram_wr_en,
  output logic [7:0] ram_wr_addr,
  output logic [7:0] ram_wr_data,
  input  logic       ext_wr,
  input  logic [7:0] ext_wr_addr,
  input  logic [7:0] ext_wr_data
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mem_q, mem_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       fwd_hit_q, fwd_hit_d;
  logic [7:0] fwd_data_q, fwd_data_d;
  logic       snoop_hit;
  logic       accept;

  assign snoop_hit = FWD_EN && ext_wr && (ext_wr_addr == addr_q);
  assign accept    = req && ((state_q == ST_IDLE) || (state_q == ST_FIN));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    mem_d      = mem_q;
    rd_data_d  = rd_data_q;
    fwd_hit_d  = fwd_hit_q;
    fwd_data_d = fwd_data_q;
    busy       = 1'b0;
    done       = 1'b0;
    ram_rd_en  = 1'b0;
    ram_wr_en  = 1'b0;

    if (accept) begin
      addr_d    = ri;
      op_d      = op_e'(op);
      acc_d     = acc_in;
      fwd_hit_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy = 1'b1;
        // A snoop hit here lands in RAM in the same cycle as our read, so
        // the RAM returns the old value; remember the new one.
        if (snoop_hit) begin
          fwd_hit_d  = 1'b1;
          fwd_data_d = ext_wr_data;
        end
        if (op_q == OP_WR) begin
          ram_wr_en = 1'b1;
          state_d   = ST_FIN;
        end else begin
          ram_rd_en = 1'b1;
          state_d   = ST_CAPT;
        end
      end
      ST_CAPT: begin
        busy = 1'b1;
        // Youngest write wins: CAPT-cycle snoop over ISSUE-cycle snoop.
        if (snoop_hit)      mem_d = ext_wr_data;
        else if (fwd_hit_q) mem_d = fwd_data_q;
        else                mem_d = ram_rd_data;
        if (op_q == OP_RD) begin
          rd_data_d = mem_d;
          state_d   = ST_FIN;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        busy      = 1'b1;
        ram_wr_en = 1'b1;
        rd_data_d = (op_q == OP_XCHD) ? xchd_merge(acc_q, mem_q) : mem_q;
        state_d   = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = accept ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data outputs come straight from held registers so they keep
  // their last value while idle.
  assign ram_rd_addr = addr_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = (op_q == OP_XCHD) ? xchd_merge(mem_q, acc_q) : acc_q;
  assign rd_data     = rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_RD;
      addr_q     <= 8'h00;
      acc_q      <= 8'h00;
      mem_q      <= 8'h00;
      rd_data_q  <= 8'h00;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_oc8051_indi_acc.sv
module tb_oc8051_indi_acc;
  import oc8051_indi_pkg::*;

  logic       clk = 1'b0;
  logic       rst, req, ext_wr;
  logic [1:0] op;
  logic [7:0] ri, acc_in, ext_wr_addr, ext_wr_data;

  logic       a_busy, a_done, a_rd_en, a_wr_en;
  logic [7:0] a_rd_data, a_rd_addr, a_wr_addr, a_wr_data, a_ram_q;
  logic       b_busy, b_done, b_rd_en, b_wr_en;
  logic [7:0] b_rd_data, b_rd_addr, b_wr_addr, b_wr_data, b_ram_q;

  logic [7:0] ram_a [0:255];
  logic [7:0] ram_b [0:255];

  logic [7:0] ref_mem [0:255];
  bit         ref_valid [0:255];

  int checks = 0;
  int errors = 0;

  int         obs_lat, obs_rd_cnt, obs_rd_cyc, obs_wr_cnt, obs_wr_cyc, obs_both, obs_busy_bad;
  logic [7:0] obs_rd_addr, obs_wr_addr, obs_wr_data, obs_rd_data, obs_rd_data_b;

  always #5 clk = ~clk;

  oc8051_indi_acc #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .ri(ri), .acc_in(acc_in),
    .busy(a_busy), .done(a_done), .rd_data(a_rd_data),
    .ram_rd_en(a_rd_en), .ram_rd_addr(a_rd_addr), .ram_rd_data(a_ram_q),
    .ram_wr_en(a_wr_en), .ram_wr_addr(a_wr_addr), .ram_wr_data(a_wr_data),
    .ext_wr(ext_wr), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data)
  );

  oc8051_indi_acc #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .req(req), .op(op), .ri(ri), .acc_in(acc_in),
    .busy(b_busy), .done(b_done), .rd_data(b_rd_data),
    .ram_rd_en(b_rd_en), .ram_rd_addr(b_rd_addr), .ram_rd_data(b_ram_q),
    .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
    .ext_wr(ext_wr), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data)
  );

  // Synchronous RAMs: read returns the pre-write contents of the cycle.
  always @(posedge clk) begin
    if (a_rd_en) a_ram_q <= ram_a[a_rd_addr];
    if (a_wr_en) ram_a[a_wr_addr] <= a_wr_data;
    if (ext_wr)  ram_a[ext_wr_addr] <= ext_wr_data;
    if (b_rd_en) b_ram_q <= ram_b[b_rd_addr];
    if (b_wr_en) ram_b[b_wr_addr] <= b_wr_data;
    if (ext_wr)  ram_b[ext_wr_addr] <= ext_wr_data;
  end

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    ext_wr = 1'b1; ext_wr_addr = addr; ext_wr_data = data;
    @(posedge clk); #1;
    ext_wr = 1'b0;
    ref_mem[addr] = data; ref_valid[addr] = 1'b1;
  endtask

  // Issue one operation starting in the current cycle (cycle 0) and observe
  // dut until done. Optional snoop writes in cycle 1 (ISSUE) and 2 (CAPT).
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] d,
                        input bit e1, input logic [7:0] ea1, input logic [7:0] ed1,
                        input bit e2, input logic [7:0] ea2, input logic [7:0] ed2);
    bit fin;
    obs_lat = 0; obs_rd_cnt = 0; obs_rd_cyc = 0; obs_wr_cnt = 0; obs_wr_cyc = 0;
    obs_both = 0; obs_busy_bad = 0;
    req = 1'b1; op = o; ri = a; acc_in = d;
    @(posedge clk); #1;
    req = 1'b0; ri = 8'($urandom); acc_in = 8'($urandom); op = 2'($urandom);
    for (int c = 1; c <= 10; c++) begin
      ext_wr      = (c == 1 && e1) || (c == 2 && e2);
      ext_wr_addr = (c == 1) ? ea1 : ea2;
      ext_wr_data = (c == 1) ? ed1 : ed2;
      @(negedge clk);
      if (a_rd_en) begin obs_rd_cnt++; obs_rd_cyc = c; obs_rd_addr = a_rd_addr; end
      if (a_wr_en) begin obs_wr_cnt++; obs_wr_cyc = c; obs_wr_addr = a_wr_addr; obs_wr_data = a_wr_data; end
      if (a_rd_en && a_wr_en) obs_both++;
      if (a_busy === a_done) obs_busy_bad++;
      fin = a_done;
      if (a_done) begin obs_lat = c; obs_rd_data = a_rd_data; obs_rd_data_b = b_rd_data; end
      @(posedge clk); #1;
      ext_wr = 1'b0;
      if (fin) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; op = 2'b00; ri = 8'h00; acc_in = 8'h00;
    ext_wr = 1'b0; ext_wr_addr = 8'h00; ext_wr_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({a_busy, a_done, a_rd_en, a_wr_en} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {a_busy, a_done, a_rd_en, a_wr_en}); end
    checks++; if ({a_rd_data, a_rd_addr, a_wr_addr, a_wr_data} !== 32'h0) begin errors++; $display("FAIL reset_values got %h exp 00000000", {a_rd_data, a_rd_addr, a_wr_addr, a_wr_data}); end
    checks++; if ({b_busy, b_done, b_rd_en, b_wr_en, b_rd_data} !== 12'h0) begin errors++; $display("FAIL reset_nf got %h exp 000", {b_busy, b_done, b_rd_en, b_wr_en, b_rd_data}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_read;
    preload(8'h30, 8'hA5);
    run_op(OP_RD, 8'h30, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    checks++; if (obs_rd_cyc !== 1 || obs_rd_cnt !== 1) begin errors++; $display("FAIL read_strobe got cyc %0d cnt %0d exp cyc 1 cnt 1", obs_rd_cyc, obs_rd_cnt); end
    checks++; if (obs_rd_addr !== 8'h30) begin errors++; $display("FAIL read_addr got %h exp 30", obs_rd_addr); end
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL read_latency got %0d exp 3", obs_lat); end
    checks++; if (obs_rd_data !== 8'hA5) begin errors++; $display("FAIL read_data got %h exp a5", obs_rd_data); end
    checks++; if (obs_wr_cnt !== 0 || obs_busy_bad !== 0) begin errors++; $display("FAIL read_misc got wr %0d busybad %0d exp 0 0", obs_wr_cnt, obs_busy_bad); end
  endtask

  task automatic test_write;
    run_op(OP_WR, 8'h7F, 8'h3C, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    ref_mem[8'h7F] = 8'h3C; ref_valid[8'h7F] = 1'b1;
    checks++; if (obs_wr_cyc !== 1 || obs_wr_cnt !== 1) begin errors++; $display("FAIL write_strobe got cyc %0d cnt %0d exp 1 1", obs_wr_cyc, obs_wr_cnt); end
    checks++; if ({obs_wr_addr, obs_wr_data} !== 16'h7F3C) begin errors++; $display("FAIL write_addr_data got %h exp 7f3c", {obs_wr_addr, obs_wr_data}); end
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL write_latency got %0d exp 2", obs_lat); end
    checks++; if (obs_rd_cnt !== 0) begin errors++; $display("FAIL write_no_read got %0d exp 0", obs_rd_cnt); end
  endtask

  task automatic test_xch;
    preload(8'h40, 8'h12);
    run_op(OP_XCH, 8'h40, 8'h34, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    ref_mem[8'h40] = 8'h34;
    checks++; if (obs_wr_cyc !== 3 || {obs_wr_addr, obs_wr_data} !== 16'h4034) begin errors++; $display("FAIL xch_write got cyc %0d %h exp 3 4034", obs_wr_cyc, {obs_wr_addr, obs_wr_data}); end
    checks++; if (obs_lat !== 4) begin errors++; $display("FAIL xch_latency got %0d exp 4", obs_lat); end
    checks++; if (obs_rd_data !== 8'h12) begin errors++; $display("FAIL xch_data got %h exp 12", obs_rd_data); end
    checks++; if (obs_both !== 0) begin errors++; $display("FAIL xch_both_strobes got %0d exp 0", obs_both); end
  endtask

  task automatic test_xchd;
    preload(8'h41, 8'h56);
    run_op(OP_XCHD, 8'h41, 8'h9A, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    ref_mem[8'h41] = 8'h5A;
    checks++; if ({obs_wr_addr, obs_wr_data} !== 16'h415A) begin errors++; $display("FAIL xchd_write got %h exp 415a", {obs_wr_addr, obs_wr_data}); end
    checks++; if (obs_rd_data !== 8'h96) begin errors++; $display("FAIL xchd_data got %h exp 96", obs_rd_data); end
    checks++; if (obs_lat !== 4) begin errors++; $display("FAIL xchd_latency got %0d exp 4", obs_lat); end
  endtask

  task automatic test_forwarding;
    preload(8'h50, 8'h11);
    run_op(OP_RD, 8'h50, 8'h00, 1, 8'h50, 8'h77, 1, 8'h50, 8'h88);
    ref_mem[8'h50] = 8'h88;
    checks++; if (obs_rd_data !== 8'h88) begin errors++; $display("FAIL fwd_both_hit got %h exp 88", obs_rd_data); end
    checks++; if (obs_rd_data_b !== 8'h11) begin errors++; $display("FAIL nofwd_both_hit got %h exp 11", obs_rd_data_b); end
    run_op(OP_RD, 8'h50, 8'h00, 1, 8'h50, 8'h77, 1, 8'h51, 8'h99);
    ref_mem[8'h50] = 8'h77; ref_mem[8'h51] = 8'h99; ref_valid[8'h51] = 1'b1;
    checks++; if (obs_rd_data !== 8'h77) begin errors++; $display("FAIL fwd_issue_hit got %h exp 77", obs_rd_data); end
    checks++; if (obs_rd_data_b !== 8'h88) begin errors++; $display("FAIL nofwd_issue_hit got %h exp 88", obs_rd_data_b); end
    run_op(OP_RD, 8'h50, 8'h00, 0, 8'h00, 8'h00, 1, 8'h50, 8'h5C);
    ref_mem[8'h50] = 8'h5C;
    checks++; if (obs_rd_data !== 8'h5C) begin errors++; $display("FAIL fwd_capt_hit got %h exp 5c", obs_rd_data); end
    checks++; if (obs_rd_data_b !== 8'h77) begin errors++; $display("FAIL nofwd_capt_hit got %h exp 77", obs_rd_data_b); end
  endtask

  task automatic test_req_busy;
    int n_done = 0, n_rd = 0, n_wr = 0, done_at = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin req = 1'b1; op = OP_RD; ri = 8'h30; acc_in = 8'h00; end
      else if (c < 3) begin req = 1'b1; op = OP_WR; ri = 8'h31; acc_in = 8'hFF; end
      else req = 1'b0;
      @(negedge clk);
      if (a_done) begin n_done++; done_at = c; end
      if (a_rd_en) n_rd++;
      if (a_wr_en) n_wr++;
      @(posedge clk); #1;
    end
    checks++; if (n_done !== 1 || done_at !== 3) begin errors++; $display("FAIL req_busy_done got cnt %0d at %0d exp 1 at 3", n_done, done_at); end
    checks++; if (n_wr !== 0 || n_rd !== 1) begin errors++; $display("FAIL req_busy_strobes got wr %0d rd %0d exp 0 1", n_wr, n_rd); end
    checks++; if (a_rd_data !== 8'hA5) begin errors++; $display("FAIL req_busy_data got %h exp a5", a_rd_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ri_at [0:15];
    int         done_cyc [$];
    logic [7:0] done_val [$];
    req = 1'b1; op = OP_RD;
    for (int c = 0; c < 16; c++) begin
      ri = 8'h80 + 8'($urandom_range(0, 15));
      ri_at[c] = ri;
      if (c == 10) req = 1'b0;
      @(negedge clk);
      if (a_done) begin done_cyc.push_back(c); done_val.push_back(a_rd_data); end
      @(posedge clk); #1;
    end
    checks++; if (done_cyc.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", done_cyc.size()); end
    for (int k = 0; k < 4 && k < done_cyc.size(); k++) begin
      checks++; if (done_cyc[k] !== 3 * (k + 1)) begin errors++; $display("FAIL b2b_cycle%0d got %0d exp %0d", k, done_cyc[k], 3 * (k + 1)); end
      checks++; if (done_val[k] !== ref_mem[ri_at[3 * k]]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", k, done_val[k], ref_mem[ri_at[3 * k]]); end
    end
  endtask

  task automatic test_reset_mid;
    int n_wr = 0;
    preload(8'h60, 8'hEE);
    req = 1'b1; op = OP_XCH; ri = 8'h60; acc_in = 8'h42;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_busy !== 1'b1 || a_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_in_capt got busy %b rd_en %b exp 1 0", a_busy, a_rd_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({a_busy, a_done, a_rd_en, a_wr_en} !== 4'b0000) begin errors++; $display("FAIL rstmid_strobes got %b exp 0000", {a_busy, a_done, a_rd_en, a_wr_en}); end
    checks++; if ({a_rd_data, a_rd_addr, a_wr_addr, a_wr_data} !== 32'h0) begin errors++; $display("FAIL rstmid_values got %h exp 00000000", {a_rd_data, a_rd_addr, a_wr_addr, a_wr_data}); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (a_wr_en) n_wr++;
    end
    @(posedge clk); #1;
    checks++; if (n_wr !== 0) begin errors++; $display("FAIL rstmid_late_write got %0d exp 0", n_wr); end
  endtask

  task automatic test_random;
    logic [1:0] o;
    logic [7:0] a, d, cap, ea1, ed1, ea2, ed2, exp_rd, exp_wr;
    bit         e1, e2;
    int         exp_lat;
    exp_rd = 8'h00;
    for (int n = 0; n < 60; n++) begin
      o = (n == 0) ? OP_RD : 2'($urandom_range(0, 3));
      a = 8'h80 + 8'($urandom_range(0, 15));
      d = 8'($urandom);
      e1 = (o != OP_WR) && ($urandom_range(0, 2) == 0);
      e2 = (o != OP_WR) && ($urandom_range(0, 2) == 0);
      ea1 = $urandom_range(0, 1) ? a : 8'h80 + 8'($urandom_range(0, 15));
      ea2 = $urandom_range(0, 1) ? a : 8'h80 + 8'($urandom_range(0, 15));
      ed1 = 8'($urandom); ed2 = 8'($urandom);
      cap = ref_mem[a];
      if (e1) begin ref_mem[ea1] = ed1; if (ea1 == a) cap = ed1; end
      if (e2) begin ref_mem[ea2] = ed2; if (ea2 == a) cap = ed2; end
      exp_wr = d;
      case (o)
        OP_RD:   begin exp_lat = 3; exp_rd = cap; end
        OP_WR:   begin exp_lat = 2; ref_mem[a] = d; end
        OP_XCH:  begin exp_lat = 4; exp_rd = cap; ref_mem[a] = d; end
        default: begin exp_lat = 4; exp_rd = {d[7:4], cap[3:0]}; exp_wr = {cap[7:4], d[3:0]}; ref_mem[a] = exp_wr; end
      endcase
      run_op(o, a, d, e1, ea1, ed1, e2, ea2, ed2);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency op %0d got %0d exp %0d", n, o, obs_lat, exp_lat); end
      checks++; if (obs_rd_data !== exp_rd) begin errors++; $display("FAIL rand%0d_rd_data op %0d got %h exp %h", n, o, obs_rd_data, exp_rd); end
      checks++; if (obs_rd_cnt !== ((o == OP_WR) ? 0 : 1) || obs_wr_cnt !== ((o == OP_RD) ? 0 : 1) || obs_both !== 0) begin errors++; $display("FAIL rand%0d_strobes op %0d got rd %0d wr %0d both %0d", n, o, obs_rd_cnt, obs_wr_cnt, obs_both); end
      if (o != OP_RD) begin
        checks++; if ({obs_wr_addr, obs_wr_data} !== {a, exp_wr}) begin errors++; $display("FAIL rand%0d_write op %0d got %h exp %h", n, o, {obs_wr_addr, obs_wr_data}, {a, exp_wr}); end
      end
      checks++; if (obs_busy_bad !== 0) begin errors++; $display("FAIL rand%0d_busy got %0d bad cycles exp 0", n, obs_busy_bad); end
    end
  endtask

  task automatic test_ram_contents;
    for (int i = 0; i < 256; i++) begin
      if (ref_valid[i]) begin
        checks++; if (ram_a[i] !== ref_mem[i]) begin errors++; $display("FAIL ram_%h got %h exp %h", i[7:0], ram_a[i], ref_mem[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 8'h00; ref_valid[i] = 1'b0; end
    test_reset;
    for (int i = 0; i < 16; i++) preload(8'h80 + 8'(i), 8'($urandom));
    test_read;
    test_write;
    test_xch;
    test_xchd;
    test_forwarding;
    test_req_busy;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_ram_contents;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
